// File: rtl/post_mux_pkg.sv
// Shared types for the post-mux index sequencer: FSM state encoding and
// the run-mode encoding used when the wrap feature is built in.
package post_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } post_mux_seq_state_t;

  localparam logic PM_MODE_ONESHOT = 1'b0;
  localparam logic PM_MODE_WRAP    = 1'b1;

endpackage

// File: rtl/post_mux_sequencer.sv
// Post-mux select sequencer: walks out_counter from START to a run-time last
// index in STEP increments. Define POST_MUX_SEQ_WRAP_EN for wrap mode + wrap_count.
module post_mux_sequencer
  import post_mux_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int START  = 1,
  parameter int STEP   = 1,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              enable,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cfg_last,
`ifdef POST_MUX_SEQ_WRAP_EN
  input  logic              mode,
  output logic [WRAP_W-1:0] wrap_count,
`endif
  output logic [WIDTH-1:0]  out_counter,
  output logic              busy,
  output logic              finished,
  output logic              done
);

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH:0]   STEP_V  = (WIDTH+1)'(STEP);

  post_mux_seq_state_t r_state;
  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_last;
  logic                r_busy;
  logic                r_fin;
  logic                r_done;

  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_next;
  logic [WIDTH-1:0]    w_cfg_last;

`ifdef POST_MUX_SEQ_WRAP_EN
  logic                r_mode;
  logic [WRAP_W-1:0]   r_wrap;
`else
  // WRAP_W only sizes the wrap counter; nothing to build without the feature.
  if (WRAP_W > 0) begin : g_no_wrap
  end
`endif

  // One extra bit on the sum so the clamp sees overflow past 2^WIDTH.
  assign w_sum      = {1'b0, r_cnt} + STEP_V;
  assign w_next     = (w_sum > {1'b0, r_last}) ? r_last : w_sum[WIDTH-1:0];
  assign w_cfg_last = (cfg_last < START_V) ? START_V : cfg_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= START_V;
      r_last  <= START_V;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_done  <= 1'b0;
`ifdef POST_MUX_SEQ_WRAP_EN
      r_mode  <= PM_MODE_ONESHOT;
      r_wrap  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_cnt   <= START_V;
        r_busy  <= 1'b0;
        r_fin   <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start) begin
              r_state <= RUN;
              r_cnt   <= START_V;
              r_last  <= w_cfg_last;
              r_busy  <= 1'b1;
              r_fin   <= 1'b0;
`ifdef POST_MUX_SEQ_WRAP_EN
              r_mode  <= mode;
              r_wrap  <= '0;
`endif
            end
          end
          RUN: begin
            if (enable) begin
              if (r_cnt != r_last) begin
                r_cnt <= w_next;
`ifdef POST_MUX_SEQ_WRAP_EN
              end else if (r_mode == PM_MODE_WRAP) begin
                r_cnt  <= START_V;
                r_done <= 1'b1;
                if (r_wrap != '1) r_wrap <= r_wrap + 1'b1;
`endif
              end else begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_fin   <= 1'b1;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_counter = r_cnt;
  assign busy        = r_busy;
  assign finished    = r_fin;
  assign done        = r_done;
`ifdef POST_MUX_SEQ_WRAP_EN
  assign wrap_count  = r_wrap;
`endif

endmodule

// File: tb/tb_post_mux_sequencer.sv
// Directed bench for post_mux_sequencer: default-parameter DUT checked against a
// cycle model via a scoreboard queue, plus a STEP=3 instance with fixed sequences.
module tb_post_mux_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, enable = 1'b0, abort = 1'b0;
  logic [6:0] cfg_last = '0;
  logic [6:0] out_counter;
  logic       busy, finished, done;

  logic       s3_start = 1'b0, s3_enable = 1'b0;
  logic [6:0] s3_last = '0;
  logic [6:0] s3_cnt;
  logic       s3_busy, s3_fin, s3_done;

`ifdef POST_MUX_SEQ_WRAP_EN
  logic       mode = 1'b0;
  logic [7:0] wrap_count;
  logic [7:0] s3_wrap;
`endif

  always #5 clk = ~clk;

  post_mux_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .abort(abort),
    .cfg_last(cfg_last),
`ifdef POST_MUX_SEQ_WRAP_EN
    .mode(mode), .wrap_count(wrap_count),
`endif
    .out_counter(out_counter), .busy(busy), .finished(finished), .done(done)
  );

  post_mux_sequencer #(.STEP(3)) u3 (
    .clk(clk), .reset(reset), .start(s3_start), .enable(s3_enable), .abort(1'b0),
    .cfg_last(s3_last),
`ifdef POST_MUX_SEQ_WRAP_EN
    .mode(1'b0), .wrap_count(s3_wrap),
`endif
    .out_counter(s3_cnt), .busy(s3_busy), .finished(s3_fin), .done(s3_done)
  );

  typedef struct {
    int cnt;
    bit busy;
    bit fin;
    bit done;
  } exp_t;

  exp_t q[$];
  int   q3[$];
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;

  // reference model of the default DUT (START=1, STEP=1, one-shot)
  int m_st, m_cnt, m_last;
  bit m_fin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 1; m_last = 1; m_fin = 0;
  endtask

  task automatic cyc(input bit s, input bit e, input bit a, input int last);
    exp_t x;
    x.done = 0;
    if (a) begin
      m_st = 0; m_cnt = 1; m_fin = 0;
    end else if (s && m_st != 1) begin
      m_st = 1; m_cnt = 1; m_last = (last < 1) ? 1 : last; m_fin = 0;
    end else if (m_st == 1 && e) begin
      if (m_cnt != m_last) m_cnt = (m_cnt + 1 > m_last) ? m_last : m_cnt + 1;
      else begin m_st = 2; m_fin = 1; x.done = 1; end
    end
    x.cnt = m_cnt; x.busy = (m_st == 1); x.fin = m_fin;
    q.push_back(x);
    start = s; enable = e; abort = a; cfg_last = 7'(last);
    @(posedge clk); #1;
    x = q.pop_front();
    check("cnt", 32'(out_counter), 32'(x.cnt));
    check("busy", 32'(busy), 32'(x.busy));
    check("finished", 32'(finished), 32'(x.fin));
    check("done", 32'(done), 32'(x.done));
    if (done === 1'b1) done_seen++;
    start = 0; abort = 0;
  endtask

  // STEP=3 instance: expectation pushed with the stimulus, popped after the edge
  task automatic cyc3(input bit s, input bit e, input int last, input int exp_cnt, input bit exp_done);
    int ec;
    q3.push_back(exp_cnt);
    s3_start = s; s3_enable = e; s3_last = 7'(last);
    start = 0; enable = 0; abort = 0;
    @(posedge clk); #1;
    ec = q3.pop_front();
    check("s3_cnt", 32'(s3_cnt), 32'(ec));
    check("s3_done", 32'(s3_done), 32'(exp_done));
    s3_start = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_cnt", 32'(out_counter), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fin", 32'(finished), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s3_cnt", 32'(s3_cnt), 32'd1);
    @(negedge clk); reset = 0;

    // full 1..64 run with enable held high
    cyc(1, 1, 0, 64);
    done_seen = 0;
    repeat (64) cyc(0, 1, 0, 0);
    check("run64_done_pulses", 32'(done_seen), 32'd1);
    check("run64_last", 32'(out_counter), 32'd64);
    check("run64_fin", 32'(finished), 32'd1);
    repeat (2) cyc(0, 1, 0, 0);
    check("done_hold", 32'(out_counter), 32'd64);

    // cfg_last below START collapses to a single-index sequence
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    done_seen = 0;
    cyc(0, 1, 0, 0);
    check("single_done", 32'(done_seen), 32'd1);
    check("single_cnt", 32'(out_counter), 32'd1);

    // run to index 20, ignored start in RUN, then abort+start together
    cyc(1, 1, 0, 64);
    repeat (19) cyc(0, 1, 0, 0);
    check("at20", 32'(out_counter), 32'd20);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 5);
    check("start_in_run_ignored", 32'(out_counter), 32'd20);
    done_seen = 0;
    cyc(1, 1, 1, 64);
    check("abort_cnt", 32'(out_counter), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    cyc(0, 1, 0, 0);
    check("abort_no_done", 32'(done_seen), 32'd0);

    // asynchronous reset between edges
    cyc(1, 1, 0, 64);
    repeat (10) cyc(0, 1, 0, 0);
    @(negedge clk); #1;
    reset = 1; #1;
    check("arst_cnt", 32'(out_counter), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_fin", 32'(finished), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    #1 reset = 0;
    model_reset();
    cyc(0, 1, 0, 0);

    // STEP=3: 1,4,7,10 and clamp 10->11 without overshoot
    cyc3(1, 0, 10, 1, 0);
    cyc3(0, 1, 10, 4, 0);
    cyc3(0, 1, 10, 7, 0);
    cyc3(0, 1, 10, 10, 0);
    cyc3(0, 1, 10, 10, 1);
    check("s3_fin", 32'(s3_fin), 32'd1);
    cyc3(1, 0, 11, 1, 0);
    cyc3(0, 1, 11, 4, 0);
    cyc3(0, 1, 11, 7, 0);
    cyc3(0, 1, 11, 10, 0);
    cyc3(0, 1, 11, 11, 0);
    cyc3(0, 1, 11, 11, 1);
    check("s3_busy_after", 32'(s3_busy), 32'd0);

`ifdef POST_MUX_SEQ_WRAP_EN
    begin
      int wseq[6]  = '{2, 3, 1, 2, 3, 1};
      bit wdone[6] = '{0, 0, 1, 0, 0, 1};
      int wcnt[6]  = '{0, 0, 1, 1, 1, 2};
      mode = 1; start = 1; enable = 0; cfg_last = 7'd3;
      @(posedge clk); #1;
      start = 0; mode = 0; enable = 1;
      check("wrap_start", 32'(out_counter), 32'd1);
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        check("wrap_cnt", 32'(out_counter), 32'(wseq[i]));
        check("wrap_done", 32'(done), 32'(wdone[i]));
        check("wrap_count", 32'(wrap_count), 32'(wcnt[i]));
        check("wrap_fin", 32'(finished), 32'd0);
        check("wrap_busy", 32'(busy), 32'd1);
      end
      abort = 1;
      @(posedge clk); #1;
      abort = 0; enable = 0;
      check("wrap_abort_busy", 32'(busy), 32'd0);
      check("wrap_abort_hold", 32'(wrap_count), 32'd2);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/post_mux_sequencer.md
# post_mux_sequencer

Parametrised successor to the PUF serial post-mux counter. It generates the mux-select/challenge index sequence from a programmable start value to a run-time last value, with an optional step. It reports progress with `busy`, a sticky `finished` and a one-cycle `done` pulse. It sits between the serial control FSM (which issues `start`, `enable` and `abort`) and the post-mux select lines driven by `out_counter`.

## Interface
Parameters:
- `WIDTH`, 7: counter width in bits.
- `START`, 1: value loaded on reset, `start` and `abort`.
- `STEP`, 1: increment per enabled cycle. Must be ≥1.
- `WRAP_W`, 8: width of the wrap counter. Used only when `POST_MUX_SEQ_WRAP_EN` is defined.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: one-cycle request to begin a sequence.
- `enable` input 1: advance qualifier while running.
- `abort` input 1: return to idle. Highest priority after `reset`.
- `cfg_last` input WIDTH: last index of the sequence. Sampled only on an accepted `start`.
- `mode` input 1: 0 = one-shot, 1 = wrap. Present only with the macro. Sampled on an accepted `start`.
- `out_counter` output WIDTH: current index.
- `busy` output 1: high in RUN.
- `finished` output 1: sticky completion flag.
- `done` output 1: one-cycle pulse at completion, and at each wrap.
- `wrap_count` output WRAP_W: completed passes. Present only with the macro.

## Operation
- State machine has three states: IDLE, RUN and DONE.
- Reset values: state IDLE, `out_counter`=START, `busy`=0, `finished`=0, `done`=0, `last_q`=START, `wrap_count`=0.
- Priority order per cycle is `abort` > `start` > `enable`.
- `abort`, in any state:
  - State goes to IDLE, `out_counter` to START, `busy` to 0 and `finished` to 0.
  - No `done` pulse is produced.
  - `wrap_count` is held.
- `start` in IDLE or DONE:
  - Loads `out_counter`=START and `last_q`=max(`cfg_last`, START).
  - Clears `finished` and `wrap_count`, then enters RUN.
- `start` in RUN is ignored.
- In RUN, `enable`=0 holds everything.
- In RUN with `enable`=1 and `out_counter` != `last_q`:
  - The sum `out_counter`+STEP is formed in WIDTH+1 bits.
  - The next value is min(sum, `last_q`). The counter saturates and never overshoots or wraps around 2^WIDTH.
- In RUN with `enable`=1 and `out_counter` == `last_q`, in one-shot mode:
  - `finished`<=1 and `done`<=1 for one cycle.
  - State goes to DONE; `out_counter` holds at `last_q`.
- `cfg_last` == START gives a single-index sequence: the first enabled cycle completes it.
- In DONE, `finished` stays 1 and `out_counter` holds; `enable` is ignored.

## Timing
- `start` sampled at edge n: `busy`=1 and `out_counter`=START are visible after edge n.
- Each enabled RUN cycle updates `out_counter` at the following edge. Latency is 1 cycle and there are no bubbles.
- Completion takes (last_q−START)/STEP rounded up, plus 1, enabled cycles after `start`.
- `done` is high for exactly one cycle, coincident with `finished` rising.
- `reset` asserted mid-sequence forces all reset values immediately, without waiting for `clk`.
- `start` and `abort` in the same cycle: `abort` wins and the state is IDLE.
- All outputs are registered.

## Configuration
- `POST_MUX_SEQ_WRAP_EN` defined:
  - Adds the `mode` and `wrap_count` ports.
  - In wrap mode, an enabled cycle at `last_q` reloads START, pulses `done` and increments `wrap_count`. `wrap_count` saturates at 2^WRAP_W−1.
  - The state stays RUN and `finished` never sets; only `abort` or `reset` ends the run.
- Undefined:
  - The `mode` and `wrap_count` ports are absent.
  - Behaviour is one-shot only.

## Structure
- Shared package `post_mux_pkg` holds:
  - The state enum `post_mux_seq_state_t` (IDLE, RUN, DONE).
  - Mode encoding constants `PM_MODE_ONESHOT`=0 and `PM_MODE_WRAP`=1.
- No sub-module. This is a single flat module; the saturating next-value logic is inline.

## Test plan
- Reset, then `start` with `cfg_last`=64 and `enable` held high (defaults) -> `out_counter` steps 1..64, `done` pulses once on the 64th enabled cycle, `finished`=1 and the counter holds at 64.
- STEP=3, START=1, `cfg_last`=10 -> sequence is 1, 4, 7, 10 with no overshoot; `done` follows the 4th enabled cycle.
- `cfg_last`=0 with START=1 -> `last_q`=1; `done` on the first enabled cycle.
- `abort` and `start` asserted together at index 20 -> IDLE, `out_counter`=1, `finished`=0, no `done`.
- `reset` pulsed asynchronously mid-run (between clock edges) -> all outputs return to reset values before the next `clk` edge.
- With the macro, `mode`=1 and `cfg_last`=3 -> sequence 1, 2, 3, 1, 2, 3…; `done` pulses on each wrap, `wrap_count` increments, `finished` stays 0.
